// File: rtl/div_iter_pkg.sv
// div_iter_pkg: micro-op codes, FSM state encodings and zero constants shared
// by the iterative divider and anything that drives it.
package div_iter_pkg;

  localparam int DivStateBus = 2;

  localparam logic [7:0] InstDivw  = 8'h60;
  localparam logic [7:0] InstModw  = 8'h61;
  localparam logic [7:0] InstDivwu = 8'h62;
  localparam logic [7:0] InstModwu = 8'h63;

  localparam logic [31:0] ZeroWord = 32'h0000_0000;
  localparam logic [4:0]  ZeroReg  = 5'h00;

  typedef enum logic [DivStateBus-1:0] {
    DivIdle = 2'd0,
    DivCalc = 2'd1,
    DivFix  = 2'd2,
    DivDone = 2'd3
  } divState_t;

endpackage

// File: rtl/div_abs_neg.sv
// div_abs_neg: conditional two's complement, used both to take operand
// magnitudes and to put the sign back on the quotient/remainder.
module div_abs_neg #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] i_value,
  input  logic             i_negate,
  output logic [WIDTH-1:0] o_result
);

  assign o_result = i_negate ? ((~i_value) + WIDTH'(1)) : i_value;

endmodule

// File: rtl/div_iter.sv
// div_iter: radix-2 non-restoring divider for div.w/mod.w/div.wu/mod.wu.
// Define DIV_EARLY_OUT_EN to bypass the iteration when the quotient is trivially 0 or all-ones.
module div_iter
  import div_iter_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int OPW   = 8,
  parameter int REGW  = 5
) (
  input  logic              Clk,
  input  logic              Rest,
  input  logic [OPW-1:0]    DivMicOperate,
  input  logic              DivAbleValue,
  input  logic [WIDTH-1:0]  Dividend,
  input  logic [WIDTH-1:0]  Divisor,
  input  logic [REGW-1:0]   ReDataAddr,
  input  logic              Flush,
  output logic              DivReady,
  output logic [WIDTH-1:0]  ResultDate,
  output logic [REGW-1:0]   ResultAddr,
  output logic              ResultAbleValue
);

  localparam int CW = $clog2(WIDTH);

  divState_t r_state;
  divState_t w_nextState;

  logic              r_isMod;
  logic              r_dividendSign;
  logic              r_divisorSign;
  logic [REGW-1:0]   r_tag;
  logic [WIDTH-1:0]  r_divisor;
  logic [WIDTH-1:0]  r_quot;
  logic [WIDTH:0]    r_partRem;
  logic [CW-1:0]     r_count;

  logic              w_opDivw;
  logic              w_opModw;
  logic              w_opDivwu;
  logic              w_opModwu;
  logic              w_validOp;
  logic              w_signedOp;
  logic              w_modOp;
  logic              w_accept;
  logic [WIDTH-1:0]  w_absA;
  logic [WIDTH-1:0]  w_absB;
  logic [WIDTH:0]    w_shifted;
  logic [WIDTH:0]    w_stepRem;
  logic [WIDTH-1:0]  w_remMag;
  logic              w_negQuot;
  logic [WIDTH-1:0]  w_quotSigned;
  logic [WIDTH-1:0]  w_remSigned;

  assign w_opDivw   = (DivMicOperate == OPW'(InstDivw));
  assign w_opModw   = (DivMicOperate == OPW'(InstModw));
  assign w_opDivwu  = (DivMicOperate == OPW'(InstDivwu));
  assign w_opModwu  = (DivMicOperate == OPW'(InstModwu));
  assign w_validOp  = w_opDivw | w_opModw | w_opDivwu | w_opModwu;
  assign w_signedOp = w_opDivw | w_opModw;
  assign w_modOp    = w_opModw | w_opModwu;
  assign w_accept   = DivAbleValue & ~Flush & w_validOp;

  div_abs_neg #(.WIDTH(WIDTH)) u_absDividend (
    .i_value  (Dividend),
    .i_negate (w_signedOp & Dividend[WIDTH-1]),
    .o_result (w_absA)
  );

  div_abs_neg #(.WIDTH(WIDTH)) u_absDivisor (
    .i_value  (Divisor),
    .i_negate (w_signedOp & Divisor[WIDTH-1]),
    .o_result (w_absB)
  );

`ifdef DIV_EARLY_OUT_EN
  logic w_earlyOut;
  assign w_earlyOut = (w_absB == '0) | (w_absA < w_absB);
`endif

  // The pre-add shift can exceed 33 bits signed, but the post-add value always fits, so wrap is harmless.
  assign w_shifted = {r_partRem[WIDTH-1:0], r_quot[WIDTH-1]};
  assign w_stepRem = r_partRem[WIDTH] ? (w_shifted + {1'b0, r_divisor})
                                      : (w_shifted - {1'b0, r_divisor});

  assign w_remMag  = r_partRem[WIDTH] ? (r_partRem[WIDTH-1:0] + r_divisor)
                                      : r_partRem[WIDTH-1:0];

  // A zero divisor keeps the all-ones quotient whatever the operand signs.
  assign w_negQuot = (r_dividendSign ^ r_divisorSign) & (r_divisor != '0);

  div_abs_neg #(.WIDTH(WIDTH)) u_fixQuot (
    .i_value  (r_quot),
    .i_negate (w_negQuot),
    .o_result (w_quotSigned)
  );

  div_abs_neg #(.WIDTH(WIDTH)) u_fixRem (
    .i_value  (w_remMag),
    .i_negate (r_dividendSign),
    .o_result (w_remSigned)
  );

  always_ff @(posedge Clk or posedge Rest) begin
    if (Rest) begin
      r_state <= DivIdle;
    end else begin
      r_state <= w_nextState;
    end
  end

  always_comb begin
    w_nextState = r_state;
    if (Flush) begin
      w_nextState = DivIdle;
    end else begin
      case (r_state)
        DivIdle: begin
          if (w_accept) begin
`ifdef DIV_EARLY_OUT_EN
            w_nextState = w_earlyOut ? DivFix : DivCalc;
`else
            w_nextState = DivCalc;
`endif
          end
        end
        DivCalc: begin
          if (r_count == CW'(WIDTH-1)) begin
            w_nextState = DivFix;
          end
        end
        DivFix:  w_nextState = DivDone;
        DivDone: w_nextState = DivIdle;
        default: w_nextState = DivIdle;
      endcase
    end
  end

  always_comb begin
    DivReady        = (r_state == DivIdle);
    ResultAbleValue = (r_state == DivDone) & ~Flush;
  end

  always_ff @(posedge Clk or posedge Rest) begin
    if (Rest) begin
      r_isMod        <= 1'b0;
      r_dividendSign <= 1'b0;
      r_divisorSign  <= 1'b0;
      r_tag          <= '0;
      r_divisor      <= '0;
      r_quot         <= '0;
      r_partRem      <= '0;
      r_count        <= '0;
      ResultDate     <= WIDTH'(ZeroWord);
      ResultAddr     <= REGW'(ZeroReg);
    end else begin
      case (r_state)
        DivIdle: begin
          if (w_accept) begin
            r_isMod        <= w_modOp;
            r_dividendSign <= w_signedOp & Dividend[WIDTH-1];
            r_divisorSign  <= w_signedOp & Divisor[WIDTH-1];
            r_tag          <= ReDataAddr;
            r_divisor      <= w_absB;
            r_count        <= '0;
`ifdef DIV_EARLY_OUT_EN
            if (w_earlyOut) begin
              r_partRem <= {1'b0, w_absA};
              r_quot    <= (w_absB == '0) ? '1 : '0;
            end else begin
              r_partRem <= '0;
              r_quot    <= w_absA;
            end
`else
            r_partRem <= '0;
            r_quot    <= w_absA;
`endif
          end
        end
        DivCalc: begin
          r_partRem <= w_stepRem;
          r_quot    <= {r_quot[WIDTH-2:0], ~w_stepRem[WIDTH]};
          r_count   <= r_count + CW'(1);
        end
        DivFix: begin
          if (!Flush) begin
            ResultDate <= r_isMod ? w_remSigned : w_quotSigned;
            ResultAddr <= r_tag;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_div_iter.sv
// tb_div_iter: scoreboard bench for div_iter; expected results and pulse cycles are queued at accept.
// Build with DIV_EARLY_OUT_EN defined to exercise the short-latency path.
module tb_div_iter;
  import div_iter_pkg::*;

  logic        Clk = 1'b0;
  logic        Rest = 1'b1;
  logic [7:0]  DivMicOperate = '0;
  logic        DivAbleValue = 1'b0;
  logic [31:0] Dividend = '0;
  logic [31:0] Divisor = '0;
  logic [4:0]  ReDataAddr = '0;
  logic        Flush = 1'b0;
  logic        DivReady;
  logic [31:0] ResultDate;
  logic [4:0]  ResultAddr;
  logic        ResultAbleValue;

  typedef struct {
    logic [31:0] data;
    logic [4:0]  addr;
    int          cycle;
    int          id;
  } expect_t;

  typedef struct packed {
    logic [7:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
  } case_t;

  expect_t scoreboard[$];
  expect_t popped;
  int testsRun = 0;
  int testsFailed = 0;
  int cycleCount = 0;
  int nextId = 0;

  case_t planCases [13] = '{
    '{InstDivw,  32'd100,        32'd7,          32'd14},
    '{InstModw,  32'd100,        32'd7,          32'd2},
    '{InstModw,  32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFF},
    '{InstDivw,  32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD},
    '{InstDivwu, 32'hFFFF_FFFF,  32'd2,          32'h7FFF_FFFF},
    '{InstDivw,  32'd5,          32'd0,          32'hFFFF_FFFF},
    '{InstModwu, 32'd5,          32'd0,          32'd5},
    '{InstDivw,  32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000},
    '{InstModw,  32'h8000_0000,  32'hFFFF_FFFF,  32'd0},
    '{InstDivwu, 32'd3,          32'd10,         32'd0},
    '{InstModwu, 32'd3,          32'd10,         32'd3},
    '{InstDivw,  32'hFFFF_FFFB,  32'd0,          32'hFFFF_FFFF},
    '{InstModw,  32'hFFFF_FFFB,  32'd0,          32'hFFFF_FFFB}
  };

  div_iter #(.WIDTH(32), .OPW(8), .REGW(5)) dut (
    .Clk             (Clk),
    .Rest            (Rest),
    .DivMicOperate   (DivMicOperate),
    .DivAbleValue    (DivAbleValue),
    .Dividend        (Dividend),
    .Divisor         (Divisor),
    .ReDataAddr      (ReDataAddr),
    .Flush           (Flush),
    .DivReady        (DivReady),
    .ResultDate      (ResultDate),
    .ResultAddr      (ResultAddr),
    .ResultAbleValue (ResultAbleValue)
  );

  always #5 Clk = ~Clk;

  always @(posedge Clk) cycleCount <= cycleCount + 1;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, actual, expected);
    end
  endtask

  function automatic logic [31:0] modelResult(input logic [7:0] op, input logic [31:0] a, input logic [31:0] b);
    logic isSigned;
    logic isMod;
    logic signed [31:0] sq;
    logic signed [31:0] sr;
    isSigned = (op == InstDivw) || (op == InstModw);
    isMod    = (op == InstModw) || (op == InstModwu);
    if (b == 32'd0) return isMod ? a : 32'hFFFF_FFFF;
    if (isSigned) begin
      if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return isMod ? 32'd0 : 32'h8000_0000;
      sq = $signed(a) / $signed(b);
      sr = $signed(a) % $signed(b);
      return isMod ? sr : sq;
    end
    return isMod ? (a % b) : (a / b);
  endfunction

  function automatic int modelLatency(input logic [7:0] op, input logic [31:0] a, input logic [31:0] b);
`ifdef DIV_EARLY_OUT_EN
    logic isSigned;
    logic [31:0] magA;
    logic [31:0] magB;
    isSigned = (op == InstDivw) || (op == InstModw);
    magA = (isSigned && a[31]) ? (32'd0 - a) : a;
    magB = (isSigned && b[31]) ? (32'd0 - b) : b;
    if (b == 32'd0 || magA < magB) return 2;
`endif
    return 34;
  endfunction

  // Holds the request until the divider is ready; the accept cycle is where DivReady was seen high.
  task automatic applyStimulus(input logic [7:0] op, input logic [31:0] a, input logic [31:0] b,
                               input logic [4:0] tag, input logic [31:0] expData, input bit push,
                               output int acceptCycle);
    expect_t e;
    bit accepted;
    accepted = 1'b0;
    acceptCycle = -1;
    DivMicOperate = op;
    Dividend = a;
    Divisor = b;
    ReDataAddr = tag;
    DivAbleValue = 1'b1;
    for (int i = 0; i < 100 && !accepted; i++) begin
      @(negedge Clk);
      if (DivReady) begin
        accepted = 1'b1;
        acceptCycle = cycleCount;
      end
    end
    if (!accepted) begin
      checkOutput("readyTimeout", {31'b0, DivReady}, 32'd1);
    end else if (push) begin
      e.data  = expData;
      e.addr  = tag;
      e.cycle = acceptCycle + modelLatency(op, a, b);
      e.id    = nextId;
      nextId++;
      scoreboard.push_back(e);
    end
    @(posedge Clk);
    #1;
    DivAbleValue = 1'b0;
  endtask

  task automatic waitDrain();
    for (int i = 0; i < 200 && scoreboard.size() != 0; i++) @(posedge Clk);
    checkOutput("drain", 32'(scoreboard.size()), 32'd0);
    repeat (2) @(posedge Clk);
    #1;
  endtask

  always @(negedge Clk) begin
    if (!Rest && ResultAbleValue) begin
      if (scoreboard.size() == 0) begin
        checkOutput("unexpectedPulse", {31'b0, ResultAbleValue}, 32'd0);
      end else begin
        popped = scoreboard.pop_front();
        checkOutput($sformatf("result%0d.data", popped.id), ResultDate, popped.data);
        checkOutput($sformatf("result%0d.addr", popped.id), {27'b0, ResultAddr}, {27'b0, popped.addr});
        checkOutput($sformatf("result%0d.cycle", popped.id), 32'(cycleCount), 32'(popped.cycle));
      end
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int acc;
    int acc2;
    int accFirst;
    logic [7:0] rop;
    logic [31:0] ra;
    logic [31:0] rb;

    repeat (3) @(posedge Clk);
    @(negedge Clk);
    checkOutput("resetReady", {31'b0, DivReady}, 32'd1);
    checkOutput("resetData", ResultDate, 32'd0);
    checkOutput("resetAddr", {27'b0, ResultAddr}, 32'd0);
    checkOutput("resetPulse", {31'b0, ResultAbleValue}, 32'd0);
    @(posedge Clk);
    #1;
    Rest = 1'b0;
    @(posedge Clk);
    #1;

    // Plan cases issued back to back; the second is held while the first is busy.
    accFirst = 0;
    for (int i = 0; i < 13; i++) begin
      applyStimulus(planCases[i].op, planCases[i].a, planCases[i].b, 5'(i + 1),
                    planCases[i].res, 1'b1, acc);
      if (i == 0) accFirst = acc;
      if (i == 1) checkOutput("backToBackAccept", 32'(acc - accFirst), 32'd35);
    end
    waitDrain();
    checkOutput("holdData", ResultDate, 32'hFFFF_FFFB);
    checkOutput("holdAddr", {27'b0, ResultAddr}, 32'd13);

    DivMicOperate = 8'hFF;
    Dividend = 32'd10;
    Divisor = 32'd2;
    DivAbleValue = 1'b1;
    @(posedge Clk);
    #1;
    DivAbleValue = 1'b0;
    @(negedge Clk);
    checkOutput("invalidOpIgnored", {31'b0, DivReady}, 32'd1);
    @(posedge Clk);
    #1;

    for (int i = 0; i < 6; i++) begin
      case (i % 4)
        0: rop = InstDivw;
        1: rop = InstModw;
        2: rop = InstDivwu;
        default: rop = InstModwu;
      endcase
      ra = $urandom;
      rb = (i % 2 == 1) ? $urandom : $urandom_range(1, 300);
      applyStimulus(rop, ra, rb, 5'(16 + i), modelResult(rop, ra, rb), 1'b1, acc);
    end
    waitDrain();

    applyStimulus(InstDivw, 32'd1000, 32'd3, 5'd24, 32'd0, 1'b0, acc);
    repeat (9) @(posedge Clk);
    #1;
    Flush = 1'b1;
    @(posedge Clk);
    #1;
    Flush = 1'b0;
    applyStimulus(InstModw, 32'd1000, 32'd3, 5'd25, 32'd1, 1'b1, acc2);
    checkOutput("acceptAfterFlush", 32'(acc2 - acc), 32'd11);
    waitDrain();

    applyStimulus(InstDivw, 32'd100, 32'd7, 5'd26, 32'd0, 1'b0, acc);
    repeat (33) @(posedge Clk);
    #1;
    Flush = 1'b1;
    @(negedge Clk);
    checkOutput("flushSuppressesPulse", {31'b0, ResultAbleValue}, 32'd0);
    @(posedge Clk);
    #1;
    Flush = 1'b0;
    repeat (3) @(posedge Clk);
    #1;

    applyStimulus(InstDivwu, 32'hFFFF_0000, 32'd3, 5'd27, 32'd0, 1'b0, acc);
    repeat (5) @(posedge Clk);
    #1;
    Rest = 1'b1;
    @(negedge Clk);
    checkOutput("midResetReady", {31'b0, DivReady}, 32'd1);
    checkOutput("midResetData", ResultDate, 32'd0);
    checkOutput("midResetAddr", {27'b0, ResultAddr}, 32'd0);
    checkOutput("midResetPulse", {31'b0, ResultAbleValue}, 32'd0);
    @(posedge Clk);
    #1;
    Rest = 1'b0;
    repeat (40) @(posedge Clk);
    #1;

    applyStimulus(InstDivw, 32'hFFFF_FF9C, 32'd7, 5'd28, 32'hFFFF_FFF2, 1'b1, acc);
    waitDrain();

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule

// File: doc/div_iter.md
Name: div_iter

Overview:
- Iterative radix-2 non-restoring integer divider for the LoongArch execute stage.
- It is the inverse-operation companion of the Booth/Wallace multiplier and sits beside it in the ALU cluster.
- It executes div.w, mod.w, div.wu and mod.wu on 32-bit operands.
- Handshake: single-request valid/ready in, one-cycle result pulse out tagged with the destination architectural register.

Parameters:
- WIDTH, 32, operand/result width.
- OPW, 8, micro-operation code width (matches MicOperateCode bus).
- REGW, 5, architectural register address width (matches ArchRegBus).

Ports:
- Clk  in  1  clock.
- Rest  in  1  reset; asynchronous, active-high.
- DivMicOperate  in  OPW  operation code: InstDivw, InstModw, InstDivwu or InstModwu.
- DivAbleValue  in  1  request valid; accepted only when DivReady=1.
- Dividend  in  WIDTH  numerator.
- Divisor  in  WIDTH  denominator.
- ReDataAddr  in  REGW  destination register tag.
- Flush  in  1  pipeline flush; cancels any in-flight operation.
- DivReady  out  1  block idle, can accept.
- ResultDate  out  WIDTH  quotient or remainder.
- ResultAddr  out  REGW  tag of the completed operation.
- ResultAbleValue  out  1  result valid, one-cycle pulse.

Behaviour:
- Clock and reset: one clock Clk; reset Rest is asynchronous and active-high.
- Reset state: FSM=IDLE; DivReady=1; ResultDate=0; ResultAddr=0; ResultAbleValue=0; all internal registers cleared.
- FSM states: IDLE, CALC, FIX, DONE.
- IDLE:
  - On DivAbleValue & ~Flush: latch op, tag, |Dividend|, |Divisor| and sign bits; go to CALC; DivReady drops the next cycle.
  - Signed ops take absolute values; unsigned ops take operands raw.
  - Unrecognised op: request ignored, stays IDLE.
- CALC:
  - 33-bit partial remainder and 32-bit quotient shift register.
  - One quotient bit per cycle: add or subtract the divisor according to the sign of the partial remainder.
  - 5-bit counter, 32 cycles, then FIX.
- FIX:
  - Remainder correction: add the divisor if the partial remainder is negative.
  - Sign application: quotient negated when the dividend sign differs from the divisor sign (signed ops only); remainder takes the dividend sign.
  - Select quotient (div.*) or remainder (mod.*); go to DONE.
- DONE:
  - ResultAbleValue=1 for exactly this cycle with ResultDate and ResultAddr.
  - Next cycle returns to IDLE with DivReady=1.
  - ResultDate and ResultAddr hold until the next DONE.
- Latency: request accepted at cycle N, ResultAbleValue at N+34; a new request is accepted at N+35 earliest.
- Divide by zero: quotient=0xFFFFFFFF, remainder=Dividend, for both signed and unsigned ops. Falls out of the algorithm; the fix step must preserve it.
- Signed overflow (0x80000000 / 0xFFFFFFFF): quotient=0x80000000, remainder=0.
- Flush in any state: FSM to IDLE next cycle; no ResultAbleValue. A Flush in the same cycle as a DONE pulse suppresses the pulse.
- DivAbleValue while DivReady=0: ignored; the requester must hold the request until ready.
- Rest asserted mid-operation: immediate return to reset state; no output pulse.

Optional Feature:
- Macro: DIV_EARLY_OUT_EN.
- Enabled: at accept, if Divisor==0 or |Dividend| < |Divisor| (magnitude compare), CALC is skipped and the FSM goes straight to FIX. The result pulses at N+2 with identical values (quotient 0 or all-ones, remainder = Dividend).
- Disabled: every operation takes the fixed 34-cycle latency.

Decomposition:
- Shared package / define.v: op codes InstDivw, InstModw, InstDivwu, InstModwu; FSM state encodings DivIdle, DivCalc, DivFix, DivDone; DivStateBus width; zero constants.
- Sub-module div_abs_neg: combinational conditional two's-complement (abs/negate). Instantiated for operand conditioning and result sign fix.

Test Plan:
- div.w 100 / 7 -> 14 at N+34; mod.w 100 % 7 -> 2; ResultAddr equals the ReDataAddr latched at accept.
- mod.w -7 % 2 -> 0xFFFFFFFF (-1); div.w -7 / 2 -> 0xFFFFFFFD (-3); div.wu 0xFFFFFFFF / 2 -> 0x7FFFFFFF.
- div.w 5 / 0 -> 0xFFFFFFFF; mod.wu 5 % 0 -> 5; div.w 0x80000000 / 0xFFFFFFFF -> 0x80000000 and mod -> 0.
- Flush at cycle N+10 -> no ResultAbleValue; DivReady=1 at N+11; a new request at N+11 completes normally.
- Back-to-back: second request held during busy -> accepted at N+35, result at N+69. Rest pulsed mid-CALC -> outputs zero, no pulse.
- DIV_EARLY_OUT_EN: div.wu 3 / 10 -> 0 at N+2; mod.wu 3 % 10 -> 3 at N+2.
